// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between the IF fetch port and the MEM load/store port.
// Optional macro ARB_RR_EN selects round-robin arbitration; when it is undefined, dm has fixed priority over if.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

  localparam int CW = 4;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  owner_e          winner;
  logic            any_req;

  assign any_req = if_req | dm_req;

`ifdef ARB_RR_EN
  // The pointer remembers the last winner; under contention the other port goes next.
  owner_e rr_q, rr_d;

  always_comb begin
    if (if_req && dm_req) winner = (rr_q == OWN_DM) ? OWN_IF : OWN_DM;
    else if (dm_req)      winner = OWN_DM;
    else                  winner = OWN_IF;
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) rr_d = winner;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= OWN_DM;
    else     rr_q <= rr_d;
  end
`else
  // The older instruction in MEM must progress, so dm always beats if.
  assign winner = dm_req ? OWN_DM : OWN_IF;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_DM;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational (no latches).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction fields are frozen at grant; requester inputs are ignored afterwards.
  always_comb begin
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          if (winner == OWN_DM) begin
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ISSUE: cnt_d = CW'(MEM_LAT - 1);
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!we_q) begin
          if (owner_q == OWN_DM) dm_rdata_d = mem_rdata;
          else                   if_rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Memory-side controls are live only during ISSUE; acks only during RESP.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ack    = 1'b0;
    dm_ack    = 1'b0;
    unique case (state_q)
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      RESP: begin
        if (owner_q == OWN_DM) dm_ack = 1'b1;
        else                   if_ack = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle-timeline model of each granted transaction plus literal latency checks.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, dm_ack, mem_en, mem_we, busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: one granted access at cycle m_g, everything else follows from its age.
  bit            m_busy = 0;
  int            m_g    = 0;
  bit            m_own  = 0;   // 1 = dm, 0 = if
  bit            m_we   = 0;
  logic [31:0]   m_addr = 0, m_wdata = 0;
  bit            m_ptr  = 1;
  logic [31:0]   exp_if = 0, exp_dm = 0;
  logic [31:0]   model_mem [logic [31:0]];

  // Memory responder seen by the DUT.
  logic [31:0]   drv_mem [logic [31:0]];
  bit            rd_pending = 0;
  int            rd_due = 0;
  logic [31:0]   rd_addr = 0;

  // Observations used by the literal checks.
  int            if_ack_cyc = -1, dm_ack_cyc = -1, issue_cyc = -1;
  int            if_cnt = 0, dm_cnt = 0;
  logic [31:0]   issue_addr = 0, issue_wdata = 0;
  logic          issue_we = 0;
  bit            auto_drop = 1;
  bit            order [$];

  function automatic logic [31:0] mread(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] dread(input logic [31:0] a);
    return drv_mem.exists(a) ? drv_mem[a] : 32'h0;
  endfunction

  // Called at a negedge: applies the current inputs to the model, advances one cycle, then compares.
  task automatic step();
    int  d;
    bit  iss, ack, w;
    mem_rdata = (rd_pending && rd_due == cyc) ? dread(rd_addr) : 32'hBAD0_BAD0;

    d = cyc - m_g;
    if (m_busy && d == 1 && m_we) model_mem[m_addr] = m_wdata;
    if (rst) begin
      m_busy = 0; m_ptr = 1; exp_if = 0; exp_dm = 0;
    end else if (m_busy) begin
      if (d == L + 1 && !m_we) begin
        if (m_own) exp_dm = mread(m_addr);
        else       exp_if = mread(m_addr);
      end
      if (d == L + 2) m_busy = 0;
    end else if (if_req || dm_req) begin
`ifdef ARB_RR_EN
      if (if_req && dm_req) w = !m_ptr;
      else                  w = dm_req;
`else
      w = dm_req;
`endif
      m_own   = w;
      m_we    = w ? dm_we : 1'b0;
      m_addr  = w ? dm_addr : if_addr;
      m_wdata = w ? dm_wdata : 32'h0;
      m_ptr   = w;
      m_g     = cyc;
      m_busy  = 1;
    end

    @(negedge clk);
    cyc++;

    d   = cyc - m_g;
    iss = m_busy && d == 1;
    ack = m_busy && d == L + 2;
    check("busy",      busy,      m_busy);
    check("mem_en",    mem_en,    iss);
    check("mem_we",    mem_we,    iss && m_we);
    check("mem_addr",  mem_addr,  iss ? m_addr : 32'h0);
    check("mem_wdata", mem_wdata, iss ? m_wdata : 32'h0);
    check("if_ack",    if_ack,    ack && !m_own);
    check("dm_ack",    dm_ack,    ack && m_own);
    check("if_rdata",  if_rdata,  exp_if);
    check("dm_rdata",  dm_rdata,  exp_dm);
    check("ack_excl",  if_ack & dm_ack, 1'b0);

    if (mem_en) begin
      rd_pending  = 1;
      rd_due      = cyc + L;
      rd_addr     = mem_addr;
      issue_cyc   = cyc;
      issue_addr  = mem_addr;
      issue_wdata = mem_wdata;
      issue_we    = mem_we;
      if (mem_we) drv_mem[mem_addr] = mem_wdata;
    end
    if (if_ack) begin
      if_ack_cyc = cyc; if_cnt++; order.push_back(1'b0);
      if (auto_drop) if_req = 0;
    end
    if (dm_ack) begin
      dm_ack_cyc = cyc; dm_cnt++; order.push_back(1'b1);
      if (auto_drop) dm_req = 0;
    end
  endtask

  initial begin
    int t;
    int n;
    model_mem[32'h10]  = 32'h0050_0093;  drv_mem[32'h10]  = 32'h0050_0093;
    model_mem[32'h20]  = 32'h1111_2222;  drv_mem[32'h20]  = 32'h1111_2222;
    model_mem[32'h200] = 32'hCAFE_F00D;  drv_mem[32'h200] = 32'hCAFE_F00D;

    // Reset held with both requests up; then contention resolves dm first.
    rst = 1; if_req = 1; if_addr = 32'h10;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200; dm_wdata = 32'h0; mem_rdata = 32'h0;
    repeat (2) step();
    check("rst_busy", busy, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    rst = 0;
    t = cyc;
    repeat (4) step();
    check("first_grant_issue", issue_cyc - t, 1);
    check("contend_dm_ack_lat", dm_ack_cyc - t, 4);
    check("contend_dm_rdata", dm_rdata, 32'hCAFE_F00D);
    repeat (5) step();
    check("contend_if_ack_lat", if_ack_cyc - t, 9);
    check("contend_if_rdata", if_rdata, 32'h0050_0093);
    step();

    // Single fetch; the address changes after grant and must not matter.
    if_req = 1; if_addr = 32'h20; t = cyc;
    step();
    if_addr = 32'hFFFF_0000;
    repeat (3) step();
    check("fetch_issue_lat", issue_cyc - t, 1);
    check("fetch_issue_addr", issue_addr, 32'h20);
    check("fetch_issue_we", issue_we, 1'b0);
    check("fetch_ack_lat", if_ack_cyc - t, 4);
    check("fetch_rdata", if_rdata, 32'h1111_2222);
    step();

    // Store; dm_rdata must keep its previous load value.
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; t = cyc;
    step();
    dm_wdata = 32'h0;
    repeat (3) step();
    check("store_issue_we", issue_we, 1'b1);
    check("store_issue_addr", issue_addr, 32'h100);
    check("store_issue_wdata", issue_wdata, 32'hDEAD_BEEF);
    check("store_ack_lat", dm_ack_cyc - t, 4);
    check("store_rdata_hold", dm_rdata, 32'hCAFE_F00D);
    step();

    // Load back the stored word.
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    repeat (5) step();
    check("load_back", dm_rdata, 32'hDEAD_BEEF);

    // Reset while waiting with if_req held: transaction dropped, then re-granted.
    if_req = 1; if_addr = 32'h10; n = if_cnt; t = cyc;
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    check("rst_midop_no_ack", if_cnt - n, 0);
    check("rst_midop_cleared", if_rdata, 32'h0);
    t = cyc;
    repeat (4) step();
    check("regrant_ack_lat", if_ack_cyc - t, 4);
    check("regrant_rdata", if_rdata, 32'h0050_0093);
    step();

    // Continuous dual requests.
    auto_drop = 0; order.delete();
    n = if_cnt;
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    repeat (21) step();
`ifdef ARB_RR_EN
    check("rr_count", order.size(), 4);
    for (int i = 1; i < order.size(); i++) check("rr_alternate", order[i], !order[i-1]);
`else
    check("fixed_no_if_ack", if_cnt - n, 0);
    check("fixed_dm_acks", order.size(), 4);
`endif
    if_req = 0; dm_req = 0;
    repeat (8) step();
    check("final_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage RISC-V pipeline.
- Each requester uses a req/ack handshake. The pipeline stalls the requesting stage while its req is high and its ack is low.
- The block owns the memory-side control (enable, write-enable, address, write data) and registers the read data back to the winner.
- It sits between Pipeline_top's fetch/memory stages and the shared memory model.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address
if_rdata  out  DW  fetch data, valid with if_ack
if_ack  out  1  one-cycle completion pulse, fetch
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_rdata  out  DW  load data, valid with dm_ack
dm_ack  out  1  one-cycle completion pulse, data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; owner register = DM; RR pointer = DM.
  - rst is sampled on clk only and takes priority over everything.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner, latch owner, addr, we and wdata into registers, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_en = 1 for exactly this cycle.
  - mem_we, mem_addr and mem_wdata are driven from the latched values.
  - Load the wait counter with MEM_LAT-1, go to WAIT.
- WAIT:
  - Decrement the counter.
  - When the counter is 0, capture mem_rdata into the owner's rdata register (loads only) and go to RESP.
- RESP:
  - Assert the owner's ack for one cycle, go to IDLE.
- Latency: req seen in IDLE at cycle t -> mem_en at t+1 -> ack at t+2+MEM_LAT. One transaction in flight at a time.
- Arbitration (default): fixed priority; dm wins over if, because the older instruction must progress.
- Requests are ignored outside IDLE.
  - A losing or new requester waits for the next IDLE.
  - Minimum spacing between two grants: MEM_LAT+3 cycles.
- Address, data and we are latched at grant. Changes to requester inputs after grant do not affect the transaction.
- Stores: dm_ack pulses as for loads; dm_rdata keeps its previous value.
- if_rdata and dm_rdata hold their values until overwritten by a later load or fetch to the same port.
- Req dropped before ack is a protocol violation. The transaction still completes and the ack still pulses.
- mem_en, mem_we, mem_addr and mem_wdata are 0 in every cycle except ISSUE.
- Reset mid-operation:
  - Returns to IDLE the next cycle and drops the transaction; no ack is issued.
  - A store already issued may have landed.
  - A requester still holding req is re-granted after rst deasserts.
- Both acks are never high in the same cycle.

Optional Feature:
ARB_RR_EN
- Defined: round-robin arbitration.
  - When both requesters are high in IDLE, the winner is the port that is not the RR pointer; the pointer updates to the winner at each grant.
  - With a single requester, that requester wins and the pointer still updates.
- Undefined: fixed dm-over-if priority; no pointer register is synthesised. Fetch can starve under continuous dm_req.

Test Plan:
1. Reset: rst=1 for 2 cycles with both reqs high -> all outputs 0, busy=0; first grant occurs the cycle after rst drops.
2. Single fetch, MEM_LAT=2:
   - Stimulus: if_req with if_addr=0x10 at cycle t; memory returns 0x00500093.
   - Response: mem_en=1, mem_we=0, mem_addr=0x10 at t+1 only; if_ack=1 with if_rdata=0x00500093 at t+4.
3. Store:
   - Stimulus: dm_req with dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF.
   - Response: mem_en=mem_we=1 with mem_addr=0x100 and mem_wdata=0xDEADBEEF for one cycle; dm_ack at t+4; dm_rdata unchanged.
4. Contention, fixed priority: if_req and dm_req both rise at t -> dm_ack at t+4, if_ack at t+9; never both acks in one cycle.
5. Reset mid-op: rst=1 for one cycle while in WAIT with if_req held -> no if_ack; the access is re-issued and if_ack arrives 4 cycles after the re-grant.
6. Continuous dual requests:
   - With ARB_RR_EN: grant order dm, if, dm, if.
   - Without ARB_RR_EN: only dm_ack pulses; no if_ack over 20 cycles.
